conv_act_requant: RTL and testbench

- Post-processing stage directly downstream of the conv2d layer.
- Sweeps the conv2d output memory element by element. Each element is rescaled with a fixed-point multiply, round and shift, then passed through ReLU (or LeakyReLU), saturated, and written to the next layer's input memory.
- Uses the same start/done/valid control and the same addr/data/en memory-port style as conv2d, so it chains directly after conv2d's done.

---
 rtl/conv_pkg.sv | 17 +
 rtl/act_requant_unit.sv | 49 ++++
 rtl/conv_act_requant.sv | 85 ++++++++
 tb/tb_conv_act_requant.sv | 132 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, product-width helper and saturation shared by the conv pipeline.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

    function automatic int prod_width(input int dw);
        return dw + 9;
    endfunction

    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

endpackage

// File: rtl/act_requant_unit.sv
// act_requant_unit: one registered stage of scale, round, shift, ReLU/LeakyReLU and saturate.
// CONV_ACT_LEAKY_RELU_EN selects LeakyReLU (slope 2^-NEG_SHIFT) instead of ReLU.
module act_requant_unit
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SCALE      = 16,
    parameter int SHIFT      = 4,
    parameter int NEG_SHIFT  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic                         valid,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int PW = prod_width(DATA_WIDTH);
    // Half an LSB of the shifted result; zero when no shift is applied.
    localparam logic signed [PW-1:0] RND = PW'((1 << SHIFT) >> 1);

    if (SCALE < 1 || SCALE > 255 || SHIFT < 0 || SHIFT > 15 || NEG_SHIFT < 0 || NEG_SHIFT >= PW) begin : g_param_chk
        $fatal(1, "act_requant_unit: SCALE, SHIFT or NEG_SHIFT out of range");
    end

    logic signed [PW-1:0] p, r, a;

    always_comb begin
        p = PW'(x) * $signed(PW'(SCALE));
        r = (p + RND) >>> SHIFT;
`ifdef CONV_ACT_LEAKY_RELU_EN
        a = r < 0 ? r >>> NEG_SHIFT : r;
`else
        a = r < 0 ? '0 : r;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            y     <= '0;
        end else begin
            valid <= en;
            if (en) y <= DATA_WIDTH'(saturate(32'(a), DATA_WIDTH));
        end
    end

endmodule

// File: rtl/conv_act_requant.sv
// conv_act_requant: sweeps conv2d output memory, requantises each element and writes it onward.
// Define CONV_ACT_LEAKY_RELU_EN to build with LeakyReLU instead of ReLU.
module conv_act_requant
    import conv_pkg::*;
#(
    parameter int CHANNELS   = 64,
    parameter int HEIGHT     = 2,
    parameter int WIDTH      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SCALE      = 16,
    parameter int SHIFT      = 4,
    parameter int NEG_SHIFT  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         done,
    output logic                         valid,
    output logic [ADDR_WIDTH-1:0]        input_addr,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    output logic                         input_en,
    output logic [ADDR_WIDTH-1:0]        output_addr,
    output logic signed [DATA_WIDTH-1:0] output_data,
    output logic                         output_we,
    output logic                         output_en
);

    localparam int N = CHANNELS * HEIGHT * WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

    if (N < 1 || N > 2 ** ADDR_WIDTH) begin : g_size_chk
        $fatal(1, "conv_act_requant: element count does not fit ADDR_WIDTH");
    end

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] rd_idx, addr_d;
    logic rd_d;

    assign input_en   = state == RUN;
    assign input_addr = rd_idx;
    assign output_en  = output_we;
    assign done       = state == DONE_ST;
    assign valid      = state == DONE_ST;

    // DRAIN ends on the cycle the last element's write is on the port.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (start ? RUN : IDLE) :
                   state == RUN   ? (rd_idx == LAST ? DRAIN : RUN) :
                   state == DRAIN ? (output_we && output_addr == LAST ? DONE_ST : DRAIN) :
                                    (start ? DONE_ST : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_idx      <= '0;
            rd_d        <= 1'b0;
            addr_d      <= '0;
            output_addr <= '0;
        end else begin
            state  <= state_nx;
            rd_idx <= state == IDLE ? '0 : (input_en ? rd_idx + 1'b1 : rd_idx);
            rd_d   <= input_en;
            if (input_en) addr_d <= rd_idx;
            if (rd_d) output_addr <= addr_d;
        end
    end

    act_requant_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .SCALE     (SCALE),
        .SHIFT     (SHIFT),
        .NEG_SHIFT (NEG_SHIFT)
    ) u_unit (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_d),
        .x    (input_data),
        .valid(output_we),
        .y    (output_data)
    );

endmodule

// File: tb/tb_conv_act_requant.sv
// tb_conv_act_requant: directed table-driven bench; DUT 0 uses identity scale, DUT 1 uses 1.5x (24/16).
module tb_conv_act_requant;

    localparam int N = 8;
`ifdef CONV_ACT_LEAKY_RELU_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    typedef struct {
        logic signed [7:0] x;
        logic signed [7:0] y_id;
        logic signed [7:0] y_sc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done [2], valid [2], ien [2], owe [2], oen [2];
    logic [7:0] ia [2], oa [2];
    logic signed [7:0] id [2], od [2];
    logic signed [7:0] mem [N];
    vec_t tbl [N];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ien[0]) id[0] <= mem[ia[0][2:0]];
        if (ien[1]) id[1] <= mem[ia[1][2:0]];
    end

    conv_act_requant #(.CHANNELS(2), .HEIGHT(2), .WIDTH(2), .DATA_WIDTH(8), .ADDR_WIDTH(8),
                       .SCALE(16), .SHIFT(4), .NEG_SHIFT(3)) dut0 (
        .clk(clk), .rst(rst), .start(start), .done(done[0]), .valid(valid[0]),
        .input_addr(ia[0]), .input_data(id[0]), .input_en(ien[0]),
        .output_addr(oa[0]), .output_data(od[0]), .output_we(owe[0]), .output_en(oen[0]));

    conv_act_requant #(.CHANNELS(2), .HEIGHT(2), .WIDTH(2), .DATA_WIDTH(8), .ADDR_WIDTH(8),
                       .SCALE(24), .SHIFT(4), .NEG_SHIFT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .done(done[1]), .valid(valid[1]),
        .input_addr(ia[1]), .input_data(id[1]), .input_en(ien[1]),
        .output_addr(oa[1]), .output_data(od[1]), .output_we(owe[1]), .output_en(oen[1]));

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s en d%0d", tag, d), 32'(ien[d]), 0);
            chk($sformatf("%s we d%0d", tag, d), 32'(owe[d]), 0);
            chk($sformatf("%s oen d%0d", tag, d), 32'(oen[d]), 0);
            chk($sformatf("%s done d%0d", tag, d), 32'(done[d]), 0);
            chk($sformatf("%s valid d%0d", tag, d), 32'(valid[d]), 0);
        end
    endtask

    // start stays high into DONE_ST to confirm no second sweep is launched.
    task automatic sweep(input string tag);
        bit en_x, we_x;
        start = 1'b1;
        for (int k = 1; k <= N + 5; k++) begin
            @(negedge clk);
            en_x = k <= N;
            we_x = k >= 3 && k <= N + 2;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s en d%0d k%0d", tag, d, k), 32'(ien[d]), 32'(en_x));
                if (en_x) chk($sformatf("%s raddr d%0d k%0d", tag, d, k), 32'(ia[d]), k - 1);
                chk($sformatf("%s we d%0d k%0d", tag, d, k), 32'(owe[d]), 32'(we_x));
                chk($sformatf("%s oen d%0d k%0d", tag, d, k), 32'(oen[d]), 32'(we_x));
                if (we_x) begin
                    chk($sformatf("%s waddr d%0d k%0d", tag, d, k), 32'(oa[d]), k - 3);
                    chk($sformatf("%s wdata d%0d k%0d", tag, d, k), 32'(od[d]),
                        d == 0 ? 32'(tbl[k-3].y_id) : 32'(tbl[k-3].y_sc));
                end
                chk($sformatf("%s done d%0d k%0d", tag, d, k), 32'(done[d]), 32'(k >= N + 3));
                chk($sformatf("%s valid d%0d k%0d", tag, d, k), 32'(valid[d]), 32'(k >= N + 3));
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk_idle({tag, " drop"});
        @(negedge clk);
        chk_idle({tag, " stay"});
    endtask

    initial begin
        tbl[0] = '{8'sd5, 8'sd5, 8'sd8};
        tbl[1] = '{8'sd127, 8'sd127, 8'sd127};
        tbl[2] = '{-8'sd128, LK ? -8'sd16 : 8'sd0, LK ? -8'sd24 : 8'sd0};
        tbl[3] = '{8'sd0, 8'sd0, 8'sd0};
        tbl[4] = '{-8'sd8, LK ? -8'sd1 : 8'sd0, LK ? -8'sd2 : 8'sd0};
        tbl[5] = '{8'sd3, 8'sd3, 8'sd5};
        tbl[6] = '{8'sd85, 8'sd85, 8'sd127};
        tbl[7] = '{8'sd84, 8'sd84, 8'sd126};
        for (int i = 0; i < N; i++) mem[i] = tbl[i].x;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset raddr d%0d", d), 32'(ia[d]), 0);
            chk($sformatf("reset waddr d%0d", d), 32'(oa[d]), 0);
            chk($sformatf("reset wdata d%0d", d), 32'(od[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");
        sweep("first");
        start = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("pre_rst en d%0d", d), 32'(ien[d]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort");
        for (int d = 0; d < 2; d++) chk($sformatf("abort raddr d%0d", d), 32'(ia[d]), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle("post_abort");
        sweep("after_rst");
        sweep("again");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
